reloj_hora_alarma: RTL



---
 rtl/reloj_hora_alarma_pkg.sv | 34 +++
 rtl/reloj_hora_alarma_sync_flanco.sv | 28 ++
 rtl/reloj_hora_alarma.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/reloj_hora_alarma_pkg.sv
// Shared definitions for the hh:mm clock with alarm: mode codes, BCD digit type
// and the two-digit BCD increment used by every counter in the block.
package reloj_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [1:0] MODO_RUN      = 2'b00;
    localparam logic [1:0] MODO_SET_HORA = 2'b01;
    localparam logic [1:0] MODO_SET_ALM  = 2'b10;

    localparam int MIN_MAX          = 59;
    localparam int HORA_MAX_DEFAULT = 23;

    // Binary constant to two BCD digits; only used on elaboration-time constants.
    function automatic logic [7:0] a_bcd(input int val);
        a_bcd = {bcd_t'(val / 10), bcd_t'(val % 10)};
    endfunction

    // Returns {wrap, next}: wrap is set when val was at max and rolled over to 00.
    function automatic logic [8:0] inc_bcd(input logic [7:0] val, input logic [7:0] max);
        bcd_t tens;
        bcd_t units;
        tens  = val[7:4];
        units = val[3:0];
        if (val == max) begin
            inc_bcd = 9'h100;
        end else if (units == 4'd9) begin
            inc_bcd = {1'b0, tens + 4'd1, 4'd0};
        end else begin
            inc_bcd = {1'b0, tens, units + 4'd1};
        end
    endfunction

endpackage

// File: rtl/reloj_hora_alarma_sync_flanco.sv
// Multi-flop synchroniser followed by a rising-edge detector; the pulse is gated
// by i_habil so the top can mask edges while the flops are still priming.
module sync_flanco #(
    parameter int SYNC_STAGES = 2
) (
    input  logic reloje,
    input  logic rst_n,
    input  logic i_async,
    input  logic i_habil,
    output logic o_pulso
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge reloje or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_pulso = i_habil & r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/reloj_hora_alarma.sv
// BCD time-of-day clock driven by an external minute tick, with settable time,
// settable alarm and an alarm flag that times out after one minute.
module reloj_hora_alarma
    import reloj_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HORA_MAX    = HORA_MAX_DEFAULT
) (
    input  logic       reloje,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic [1:0] modo,
    input  logic       inc_min,
    input  logic       inc_hora,
    input  logic       alarm_en,
    input  logic       alarm_stop,
    output logic [7:0] hora_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] alm_hora_bcd,
    output logic [7:0] alm_min_bcd,
    output logic       alarma
);

    localparam logic [7:0] MIN_MAX_BCD  = a_bcd(MIN_MAX);
    localparam logic [7:0] HORA_MAX_BCD = a_bcd(HORA_MAX);
    localparam int         PRIME_W      = $clog2(SYNC_STAGES + 2);
    localparam logic [PRIME_W-1:0] PRIME_FIN = PRIME_W'(SYNC_STAGES + 1);

    logic [PRIME_W-1:0] r_prime;
    logic [7:0]         r_hora;
    logic [7:0]         r_min;
    logic [7:0]         r_alm_hora;
    logic [7:0]         r_alm_min;
    logic               r_alarma;
    logic               r_chk;

    logic       w_primed;
    logic       w_min_tick;
    logic       w_p_min;
    logic       w_p_hora;
    logic       w_p_stop;
    logic       w_set_hora;
    logic       w_set_alm;
    logic       w_run;
    logic       w_clr;
    logic       w_set;
    logic [8:0] w_min_nxt;
    logic [8:0] w_hora_nxt;
    logic [8:0] w_alm_min_nxt;
    logic [8:0] w_alm_hora_nxt;

    // Edges are masked until the synchroniser and edge flops hold real samples.
    always_ff @(posedge reloje or negedge rst_n) begin
        if (!rst_n) begin
            r_prime <= '0;
        end else if (!w_primed) begin
            r_prime <= r_prime + 1'b1;
        end
    end

    assign w_primed = (r_prime == PRIME_FIN);

    sync_flanco #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tick (
        .reloje(reloje), .rst_n(rst_n), .i_async(tick_in),    .i_habil(w_primed), .o_pulso(w_min_tick)
    );
    sync_flanco #(.SYNC_STAGES(SYNC_STAGES)) u_sync_min (
        .reloje(reloje), .rst_n(rst_n), .i_async(inc_min),    .i_habil(w_primed), .o_pulso(w_p_min)
    );
    sync_flanco #(.SYNC_STAGES(SYNC_STAGES)) u_sync_hora (
        .reloje(reloje), .rst_n(rst_n), .i_async(inc_hora),   .i_habil(w_primed), .o_pulso(w_p_hora)
    );
    sync_flanco #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stop (
        .reloje(reloje), .rst_n(rst_n), .i_async(alarm_stop), .i_habil(w_primed), .o_pulso(w_p_stop)
    );

    assign w_set_hora = (modo == MODO_SET_HORA);
    assign w_set_alm  = (modo == MODO_SET_ALM);
    assign w_run      = !w_set_hora && !w_set_alm;

    assign w_min_nxt      = inc_bcd(r_min,      MIN_MAX_BCD);
    assign w_hora_nxt     = inc_bcd(r_hora,     HORA_MAX_BCD);
    assign w_alm_min_nxt  = inc_bcd(r_alm_min,  MIN_MAX_BCD);
    assign w_alm_hora_nxt = inc_bcd(r_alm_hora, HORA_MAX_BCD);

    // Time runs in both run and set-alarm modes; while setting time, ticks are dropped.
    always_ff @(posedge reloje or negedge rst_n) begin
        if (!rst_n) begin
            r_hora <= '0;
            r_min  <= '0;
        end else if (w_set_hora) begin
            if (w_p_min) begin
                r_min <= w_min_nxt[7:0];
            end
            if (w_p_hora) begin
                r_hora <= w_hora_nxt[7:0];
            end
        end else if (w_min_tick) begin
            r_min <= w_min_nxt[7:0];
            if (w_min_nxt[8]) begin
                r_hora <= w_hora_nxt[7:0];
            end
        end
    end

    always_ff @(posedge reloje or negedge rst_n) begin
        if (!rst_n) begin
            r_alm_hora <= '0;
            r_alm_min  <= '0;
        end else if (w_set_alm) begin
            if (w_p_min) begin
                r_alm_min <= w_alm_min_nxt[7:0];
            end
            if (w_p_hora) begin
                r_alm_hora <= w_alm_hora_nxt[7:0];
            end
        end
    end

    // r_chk marks the cycle right after a tick-driven update in run mode; only
    // then is a match allowed to raise the alarm, so manual setting never does.
    assign w_clr = w_p_stop | ~alarm_en | w_min_tick;
    assign w_set = r_chk & alarm_en & (r_hora == r_alm_hora) & (r_min == r_alm_min);

    always_ff @(posedge reloje or negedge rst_n) begin
        if (!rst_n) begin
            r_chk    <= 1'b0;
            r_alarma <= 1'b0;
        end else begin
            r_chk <= w_min_tick & w_run;
            if (w_clr) begin
                r_alarma <= 1'b0;
            end else if (w_set) begin
                r_alarma <= 1'b1;
            end
        end
    end

    assign hora_bcd     = r_hora;
    assign min_bcd      = r_min;
    assign alm_hora_bcd = r_alm_hora;
    assign alm_min_bcd  = r_alm_min;
    assign alarma       = r_alarma;

endmodule
